// File: rtl/mix_columns_serial.sv
// Column-serial AES MixColumns / InvMixColumns: one 32-bit column per clock through a
// shared GF(2^8) datapath, result held on dout until the consumer accepts it.
module mix_columns_serial #(
  parameter bit ENABLE_INV = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] din,
  input  logic         inv,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] dout,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t       state, state_nxt;
  logic [127:0] s;
  logic         m;
  logic [1:0]   col;
  logic [31:0]  col_in, col_out;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row 0 lives in the MSB byte of the column word.
  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv_mode);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] p3 [4];
    logic [7:0] p9 [4];
    logic [7:0] pb [4];
    logic [7:0] pd [4];
    logic [7:0] pe [4];
    logic [7:0] r  [4];
    a[0] = c[31:24];
    a[1] = c[23:16];
    a[2] = c[15:8];
    a[3] = c[7:0];
    for (int i = 0; i < 4; i++) begin
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      p3[i] = x2[i] ^ a[i];
      p9[i] = x8[i] ^ a[i];
      pb[i] = x8[i] ^ x2[i] ^ a[i];
      pd[i] = x8[i] ^ x4[i] ^ a[i];
      pe[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    if (ENABLE_INV && inv_mode) begin
      r[0] = pe[0] ^ pb[1] ^ pd[2] ^ p9[3];
      r[1] = p9[0] ^ pe[1] ^ pb[2] ^ pd[3];
      r[2] = pd[0] ^ p9[1] ^ pe[2] ^ pb[3];
      r[3] = pb[0] ^ pd[1] ^ p9[2] ^ pe[3];
    end else begin
      r[0] = x2[0] ^ p3[1] ^ a[2]  ^ a[3];
      r[1] = a[0]  ^ x2[1] ^ p3[2] ^ a[3];
      r[2] = a[0]  ^ a[1]  ^ x2[2] ^ p3[3];
      r[3] = p3[0] ^ a[1]  ^ a[2]  ^ x2[3];
    end
    return {r[0], r[1], r[2], r[3]};
  endfunction

  always_comb begin
    col_in = s[127:96];
    case (col)
      2'd1:    col_in = s[95:64];
      2'd2:    col_in = s[63:32];
      2'd3:    col_in = s[31:0];
      default: col_in = s[127:96];
    endcase
    col_out = mix_col(col_in, m);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = CALC;
      CALC:    if (col == 2'd3) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s     <= '0;
      m     <= 1'b0;
      col   <= 2'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            s   <= din;
            m   <= inv & ENABLE_INV;
            col <= 2'd0;
          end
        end
        CALC: begin
          case (col)
            2'd0:    s[127:96] <= col_out;
            2'd1:    s[95:64]  <= col_out;
            2'd2:    s[63:32]  <= col_out;
            default: s[31:0]   <= col_out;
          endcase
          col <= col + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode state only, so no path from in_valid/out_ready reaches them.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign dout      = s;

endmodule

// File: tb/tb_mix_columns_serial.sv
// Directed bench for mix_columns_serial: FIPS-197 vectors, inverse, backpressure,
// mid-operation reset, streaming, and a forward-only (ENABLE_INV=0) instance.
module tb_mix_columns_serial;

  localparam logic [127:0] V_SR   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] V_MC   = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] V_COL  = 128'hdb135345f20a225c01010101c6c6c6c6;
  localparam logic [127:0] V_COLR = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
  localparam logic [127:0] V_MC2  = 128'hc6b54f3a1edcacc62ab783073002b6c0;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] din;
  logic         inv;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] dout;
  logic         out_valid;
  logic         out_ready;

  logic [127:0] din_b;
  logic         inv_b;
  logic         in_valid_b;
  logic         in_ready_b;
  logic [127:0] dout_b;
  logic         out_valid_b;
  logic         out_ready_b;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mix_columns_serial #(.ENABLE_INV(1'b1)) dut (
    .clk(clk), .rst(rst), .din(din), .inv(inv), .in_valid(in_valid),
    .in_ready(in_ready), .dout(dout), .out_valid(out_valid), .out_ready(out_ready)
  );

  mix_columns_serial #(.ENABLE_INV(1'b0)) dut_fwd (
    .clk(clk), .rst(rst), .din(din_b), .inv(inv_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .dout(dout_b), .out_valid(out_valid_b), .out_ready(out_ready_b)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer one block, expect out_valid exactly 4 cycles after the accept, then release it.
  task automatic run_block(input logic [127:0] d, input logic m, input logic [127:0] exp,
                           input string tag);
    int n;
    @(negedge clk);
    din = d; inv = m; in_valid = 1'b1; out_ready = 1'b0;
    chk({tag, "_in_ready"}, 128'(in_ready), 128'd1);
    @(negedge clk);
    in_valid = 1'b0; din = ~d;
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 128'(n), 128'd4);
    chk({tag, "_dout"}, dout, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_released"}, 128'({out_valid, in_ready}), 128'b01);
  endtask

  initial begin
    int n;
    int nacc;
    int nout;
    int nhigh;
    int acc_cyc [3];
    int out_cyc [3];
    logic [127:0] blk   [3];
    logic         blk_m [3];
    logic [127:0] blk_r [3];

    rst = 1'b1; din = '0; inv = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    din_b = '0; inv_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_out_valid", 128'(out_valid), 128'd0);
    chk("reset_in_ready", 128'(in_ready), 128'd1);
    chk("reset_dout", dout, 128'd0);
    chk("reset_fwd_dout", dout_b, 128'd0);

    run_block(V_SR, 1'b0, V_MC, "fips_fwd");
    run_block(V_MC, 1'b1, V_SR, "fips_inv");
    run_block(V_COL, 1'b0, V_COLR, "per_column");

    // inv is forced low when the inverse datapath is absent
    @(negedge clk);
    din_b = V_MC; inv_b = 1'b1; in_valid_b = 1'b1;
    @(negedge clk);
    in_valid_b = 1'b0;
    n = 0;
    while (!out_valid_b && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("noinv_latency", 128'(n), 128'd4);
    chk("noinv_dout", dout_b, V_MC2);
    out_ready_b = 1'b1;
    @(negedge clk);
    out_ready_b = 1'b0;
    chk("noinv_released", 128'({out_valid_b, in_ready_b}), 128'b01);

    // Backpressure: a competing block is offered the whole time the result is held
    @(negedge clk);
    din = V_SR; inv = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    din = V_COL;
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("bp_latency", 128'(n), 128'd4);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_dout", dout, V_MC);
      chk("bp_hold_flags", 128'({out_valid, in_ready}), 128'b10);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_in_ready", 128'(in_ready), 128'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_captured", 128'(in_ready), 128'd0);
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("bp_next_latency", 128'(n), 128'd4);
    chk("bp_next_dout", dout, V_COLR);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset while column 2 is being computed
    @(negedge clk);
    din = V_SR; inv = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_flags", 128'({out_valid, in_ready}), 128'b01);
    chk("midrst_dout", dout, 128'd0);
    run_block(V_SR, 1'b0, V_MC, "after_rst");

    // Streaming with in_valid and out_ready held high
    blk[0] = V_SR;  blk_m[0] = 1'b0; blk_r[0] = V_MC;
    blk[1] = V_COL; blk_m[1] = 1'b0; blk_r[1] = V_COLR;
    blk[2] = V_MC;  blk_m[2] = 1'b1; blk_r[2] = V_SR;
    nacc = 0; nout = 0; nhigh = 0;
    acc_cyc = '{0, 0, 0};
    out_cyc = '{0, 0, 0};
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 25; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        nhigh++;
        if (nout < 3) begin
          chk("stream_dout", dout, blk_r[nout]);
          out_cyc[nout] = cyc;
          nout++;
        end
      end
      if (in_ready) begin
        if (nacc < 3) begin
          din = blk[nacc]; inv = blk_m[nacc]; in_valid = 1'b1;
          acc_cyc[nacc] = cyc;
          nacc++;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b0;
    chk("stream_accepts", 128'(nacc), 128'd3);
    chk("stream_outputs", 128'(nout), 128'd3);
    chk("stream_pulse_width", 128'(nhigh), 128'd3);
    chk("stream_acc_gap1", 128'(acc_cyc[1] - acc_cyc[0]), 128'd6);
    chk("stream_acc_gap2", 128'(acc_cyc[2] - acc_cyc[1]), 128'd6);
    chk("stream_out_lat", 128'(out_cyc[0] - acc_cyc[0]), 128'd5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
